// File: rtl/tts_pkg.sv
// Shared types and widths for the truth-table sweeper.
// Pure declarations: no latency, no flow control.
package tts_pkg;
  localparam int TTS_N_IN = 7;
  localparam int TBL_W    = 1 << TTS_N_IN;
  localparam int CNT_W    = TTS_N_IN + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } tts_state_t;
endpackage

// File: rtl/tts_lat_pipe.sv
// Delays {valid, index} by PIPE_LAT cycles to line up with the DUT response.
// Latency PIPE_LAT (0 = passthrough); free-running, no backpressure.
module tts_lat_pipe #(
  parameter int W        = 8,
  parameter int PIPE_LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  generate
    if (PIPE_LAT == 0) begin : g_pass
      logic w_unused;
      assign w_unused = &{1'b0, i_clk, i_rst};
      assign o_dat    = i_dat;
    end else begin : g_pipe
      logic [W-1:0] r_sh [PIPE_LAT];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int i = 0; i < PIPE_LAT; i++) r_sh[i] <= '0;
        end else begin
          r_sh[0] <= i_dat;
          for (int i = 1; i < PIPE_LAT; i++) r_sh[i] <= r_sh[i-1];
        end
      end

      assign o_dat = r_sh[PIPE_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2^N_IN input vectors into a function, captures its truth table and compares it.
// Start to done is 1 + 2^N_IN + PIPE_LAT cycles; no stalls, start ignored while busy, abort returns to idle.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter  int N_IN     = TTS_N_IN,
  parameter  int PIPE_LAT = 1,
  localparam int TW       = 1 << N_IN,
  localparam int CW       = N_IN + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [TW-1:0]   expected,
  output logic [N_IN-1:0] x_o,
  input  logic            f_i,
  output logic            busy,
  output logic            done,
  output logic            match,
  output logic [TW-1:0]   truth_table,
  output logic [N_IN-1:0] first_mismatch,
  output logic [CW-1:0]   mismatch_cnt
);

  tts_state_t      r_state;
  logic [N_IN-1:0] r_idx;
  logic [N_IN-1:0] r_x;
  logic [N_IN-1:0] r_first;
  logic [TW-1:0]   r_exp;
  logic [TW-1:0]   r_tt;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_drn;
  logic            r_busy;
  logic            r_done;
  logic            r_match;

  logic            w_smp_vld;
  logic [N_IN-1:0] w_smp_idx;
  logic            w_cap;
  logic            w_mm;
  logic            w_last;
  logic [CW-1:0]   w_cnt_nxt;

  tts_lat_pipe #(
    .W        (N_IN + 1),
    .PIPE_LAT (PIPE_LAT)
  ) u_lat_pipe (
    .i_clk (clk),
    .i_rst (rst),
    .i_dat ({r_state == ST_SWEEP, r_x}),
    .o_dat ({w_smp_vld, w_smp_idx})
  );

  // Samples still in flight after an abort land in IDLE and are discarded.
  assign w_cap     = w_smp_vld && (r_state != ST_IDLE);
  assign w_mm      = w_cap && (f_i != r_exp[w_smp_idx]);
  assign w_cnt_nxt = r_cnt + CW'(w_mm);
  assign w_last    = (r_idx == {N_IN{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_x     <= '0;
      r_first <= '0;
      r_exp   <= '0;
      r_tt    <= '0;
      r_cnt   <= '0;
      r_drn   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_cap) begin
        r_tt[w_smp_idx] <= f_i;
        if (w_mm) begin
          r_cnt <= w_cnt_nxt;
          if (r_cnt == '0) r_first <= w_smp_idx;
        end
      end

      if (abort && (r_state != ST_IDLE)) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_match <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start && !abort) begin
              r_exp   <= expected;
              r_tt    <= '0;
              r_cnt   <= '0;
              r_first <= '0;
              r_match <= 1'b0;
              r_idx   <= '0;
              r_x     <= '0;
              r_busy  <= 1'b1;
              r_state <= ST_SWEEP;
            end
          end
          ST_SWEEP: begin
            // The counter wraps after the last vector; x_o keeps the last one issued.
            r_idx <= r_idx + N_IN'(1);
            if (w_last) begin
              if (PIPE_LAT == 0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_match <= (w_cnt_nxt == '0);
              end else begin
                r_state <= ST_DRAIN;
                r_drn   <= '0;
              end
            end else begin
              r_x <= r_idx + N_IN'(1);
            end
          end
          ST_DRAIN: begin
            if (r_drn == 8'(PIPE_LAT - 1)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_match <= (w_cnt_nxt == '0);
            end else begin
              r_drn <= r_drn + 8'd1;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign x_o            = r_x;
  assign busy           = r_busy;
  assign done           = r_done;
  assign match          = r_match;
  assign truth_table    = r_tt;
  assign first_mismatch = r_first;
  assign mismatch_cnt   = r_cnt;

endmodule
